adc_capture_seq: RTL and testbench
==================================

ADC_CAPTURE_SEQ -- requirements
Module: adc_capture_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, capture FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 1023, max pll_clk cycles in WAIT_DONE before abort.
REQ-003 pll_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cfg_ena  in  1  sequencer/ADC enable.
REQ-006 cfg_clkdiv  in  8  adc_clk half-period minus 1, in pll_clk cycles.
REQ-007 cfg_inputsrc  in  2  ADC input mux select.
REQ-008 start  in  1  single-conversion request, one-cycle pulse.
REQ-009 cont  in  1  continuous-conversion mode.
REQ-010 clear_flags  in  1  pulse; clears overflow and timeout.
REQ-011 adc_ena, adc_convert, adc_clk  out  1 each  to ADC macro.
REQ-012 adc_inputsrc  out  2  to ADC macro.
REQ-013 adc_data  in  10; adc_done  in  1  from ADC macro, asynchronous to pll_clk.
REQ-014 rd_en  in  1  pop FIFO head.
REQ-015 rd_data  out  10  FIFO head, first-word fall-through.
REQ-016 empty, full, overflow, timeout, busy, irq  out  1 each  status.
REQ-017 level  out  5  FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-018 adc_ena SHALL equal cfg_ena registered one cycle.
REQ-019 adc_clk SHALL toggle every cfg_clkdiv+1 pll_clk cycles while adc_ena=1, else held 0 with divider counter cleared.
REQ-020 adc_done SHALL pass a 2-flop synchronizer; a rising edge of the synchronized signal is "done_rise".
REQ-021 FSM states IDLE, CONVERT, WAIT_DONE, CAPTURE; busy=1 in any state except IDLE.
REQ-022 IDLE->CONVERT when cfg_ena=1 and (start=1 or cont=1); adc_inputsrc latches cfg_inputsrc on this transition and holds until next transition.
REQ-023 CONVERT: adc_convert=1 for exactly 2*(cfg_clkdiv+1) pll_clk cycles, then ->WAIT_DONE.
REQ-024 WAIT_DONE: done_rise ->CAPTURE; after TIMEOUT cycles without done_rise set timeout sticky and ->IDLE, no FIFO write.
REQ-025 CAPTURE (one cycle): adc_data written to FIFO, ->IDLE; in cont mode next conversion starts from IDLE the following cycle.
REQ-026 start while busy=1 SHALL be ignored, not queued.
REQ-027 cfg_ena=0 in any non-IDLE state SHALL force IDLE next cycle, adc_convert=0, no FIFO write; FIFO contents retained.
REQ-028 FIFO write when full and rd_en=0 SHALL drop data and set overflow sticky; write when full with rd_en=1 SHALL succeed, no overflow.
REQ-029 rd_en when empty SHALL be ignored; rd_data SHALL hold last value.
REQ-030 Simultaneous write and read when not empty SHALL leave level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-031 empty=(level==0), full=(level==FIFO_DEPTH), combinational from level.
REQ-032 clear_flags SHALL clear overflow and timeout; if a set condition occurs the same cycle, set wins.
REQ-033 irq SHALL equal (!empty) | overflow | timeout, registered.

Reset
REQ-034 reset SHALL asynchronously force: FSM IDLE, adc_ena=0, adc_convert=0, adc_clk=0, adc_inputsrc=0, FIFO pointers and level=0, rd_data=0, empty=1, full=0, overflow=0, timeout=0, busy=0, irq=0, synchronizer flops=0.
REQ-035 reset asserted mid-conversion SHALL discard the conversion; on release FSM waits in IDLE for a new request.

Verification
REQ-036 cfg_ena=1, cfg_clkdiv=1, start pulse, model returns done after 20 cycles with data 10'h2A5 -> adc_convert high 4 cycles, rd_data=10'h2A5, level=1, irq=1.
REQ-037 cont=1, 5 conversions, no reads, FIFO_DEPTH=4 -> level=4, full=1, overflow=1, rd_data = first sample; four pops return samples 1-4 in order.
REQ-038 start, model never asserts done, TIMEOUT=1023 -> timeout=1 at 1023 cycles after WAIT_DONE entry, level=0, busy=0; clear_flags -> timeout=0.
REQ-039 cfg_ena deasserted during WAIT_DONE, then done pulse arrives -> no FIFO write, adc_ena=0, adc_clk held 0.
REQ-040 FIFO full, rd_en coincident with CAPTURE -> level stays 4, overflow=0; rd_en on empty -> level 0, rd_data unchanged.
REQ-041 reset asserted during CONVERT -> adc_convert=0 immediately (no clock edge), all REQ-034 values observed.

Source files
------------

// File: rtl/adc_capture_seq_if.sv
// adc_capture_seq_if
//   Bundles the signals exchanged between the capture sequencer and the ADC
//   macro.
//   master : sequencer side  -> drives adc_ena/adc_convert/adc_clk/adc_inputsrc,
//                               receives adc_data/adc_done
//   slave  : ADC macro side  -> the mirror image
interface adc_capture_seq_if;
  logic       adc_ena;
  logic       adc_convert;
  logic       adc_clk;
  logic [1:0] adc_inputsrc;
  logic [9:0] adc_data;
  logic       adc_done;

  modport master (
    output adc_ena, adc_convert, adc_clk, adc_inputsrc,
    input  adc_data, adc_done
  );

  modport slave (
    input  adc_ena, adc_convert, adc_clk, adc_inputsrc,
    output adc_data, adc_done
  );
endinterface

// File: rtl/adc_capture_seq.sv
// adc_capture_seq
//   Sequences single or continuous conversions of an external ADC macro,
//   generates its divided clock, waits for the (asynchronous) done flag with a
//   timeout, and stores results in a first-word fall-through capture FIFO.
//
//   Ports
//     pll_clk, reset            sole clock, async active-high reset
//     cfg_ena                   sequencer / ADC enable
//     cfg_clkdiv                adc_clk half-period minus 1, in pll_clk cycles
//     cfg_inputsrc              ADC input mux select, latched per conversion
//     start, cont               single request pulse / continuous mode
//     clear_flags               pulse, clears overflow and timeout
//     adc (master modport)      ADC macro signals
//     rd_en, rd_data            FIFO pop and FWFT head
//     empty, full, level        FIFO status
//     overflow, timeout         sticky error flags
//     busy, irq                 sequencer active / registered interrupt
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for start or cont with cfg_ena set
//   CONVERT   | adc_convert held high for two adc_clk half-periods
//   WAIT_DONE | waiting for synchronized done rising edge, bounded by TIMEOUT
//   CAPTURE   | one cycle, push adc_data into the FIFO
module adc_capture_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                     pll_clk,
  input  logic                     reset,
  input  logic                     cfg_ena,
  input  logic [7:0]               cfg_clkdiv,
  input  logic [1:0]               cfg_inputsrc,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     clear_flags,
  adc_capture_seq_if.master        adc,
  input  logic                     rd_en,
  output logic [9:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     timeout,
  output logic                     busy,
  output logic                     irq,
  output logic [4:0]               level
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);
  localparam logic [4:0]    DEPTH_LVL = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CONVERT   = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_CAPTURE   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic          adc_ena_q, adc_ena_d;
  logic [7:0]    div_cnt_q, div_cnt_d;
  logic          adc_clk_q, adc_clk_d;
  logic [2:0]    done_sync_q, done_sync_d;
  logic [8:0]    conv_cnt_q, conv_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          adc_convert_q, adc_convert_d;
  logic [1:0]    inputsrc_q, inputsrc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [9:0]    rd_data_q, rd_data_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;
  logic          irq_q, irq_d;
  logic [9:0]    mem_q [FIFO_DEPTH];

  logic          done_rise;
  logic          timeout_set;
  logic          fifo_wr_req;
  logic          fifo_empty;
  logic          fifo_full;
  logic          wr_ok;
  logic          rd_ok;
  logic          ovf_set;
  logic [PW-1:0] rd_ptr_inc;

  // ---------------------------------------------------------------------------
  // ADC enable and clock divider
  // ---------------------------------------------------------------------------
  assign adc_ena_d = cfg_ena;

  always_comb begin
    div_cnt_d = div_cnt_q;
    adc_clk_d = adc_clk_q;
    if (!adc_ena_q) begin
      div_cnt_d = '0;
      adc_clk_d = 1'b0;
    end else if (div_cnt_q >= cfg_clkdiv) begin
      // >= keeps the divider sane if cfg_clkdiv is lowered mid-count
      div_cnt_d = '0;
      adc_clk_d = ~adc_clk_q;
    end else begin
      div_cnt_d = div_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // adc_done synchronizer: two flops plus one history flop for edge detect
  // ---------------------------------------------------------------------------
  assign done_sync_d = {done_sync_q[1:0], adc.adc_done};
  assign done_rise   = done_sync_q[1] & ~done_sync_q[2];

  // ---------------------------------------------------------------------------
  // Sequencer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    conv_cnt_d  = conv_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    inputsrc_d  = inputsrc_q;
    timeout_set = 1'b0;
    fifo_wr_req = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_ena && (start || cont)) begin
          state_d    = S_CONVERT;
          inputsrc_d = cfg_inputsrc;
          // 2*(clkdiv+1) cycles counted down to zero inclusive
          conv_cnt_d = {cfg_clkdiv, 1'b1};
        end
      end
      S_CONVERT: begin
        if (conv_cnt_q == 9'd0) begin
          state_d    = S_WAIT_DONE;
          wait_cnt_d = WAIT_LOAD;
        end else begin
          conv_cnt_d = conv_cnt_q - 9'd1;
        end
      end
      S_WAIT_DONE: begin
        if (done_rise) begin
          state_d = S_CAPTURE;
        end else if (wait_cnt_q == '0) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - TW'(1);
        end
      end
      S_CAPTURE: begin
        fifo_wr_req = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping the enable aborts whatever is in flight, without side effects
    if (state_q != S_IDLE && !cfg_ena) begin
      state_d     = S_IDLE;
      timeout_set = 1'b0;
      fifo_wr_req = 1'b0;
    end
  end

  assign adc_convert_d = (state_d == S_CONVERT);

  // ---------------------------------------------------------------------------
  // Capture FIFO
  // adc_data is sampled directly: it is stable by the time the done edge has
  // crossed the synchronizer.
  // ---------------------------------------------------------------------------
  assign fifo_empty = (level_q == 5'd0);
  assign fifo_full  = (level_q == DEPTH_LVL);
  assign rd_ok      = rd_en && !fifo_empty;
  assign wr_ok      = fifo_wr_req && (!fifo_full || rd_en);
  assign ovf_set    = fifo_wr_req && fifo_full && !rd_en;
  assign rd_ptr_inc = rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d  = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = rd_ok ? rd_ptr_inc : rd_ptr_q;
    level_d   = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase

    // rd_data is a register tracking the head; it only moves when the head
    // changes, so it keeps the last popped word once the FIFO drains.
    rd_data_d = rd_data_q;
    if (rd_ok) begin
      if (level_q > 5'd1) begin
        rd_data_d = mem_q[rd_ptr_inc];
      end else if (wr_ok) begin
        rd_data_d = adc.adc_data;
      end
    end else if (wr_ok && fifo_empty) begin
      rd_data_d = adc.adc_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Flags and interrupt (set beats clear)
  // ---------------------------------------------------------------------------
  always_comb begin
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    if (clear_flags) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (ovf_set)     overflow_d = 1'b1;
    if (timeout_set) timeout_d  = 1'b1;
  end

  assign irq_d = !fifo_empty | overflow_q | timeout_q;

  // ---------------------------------------------------------------------------
  // Sequential
  // ---------------------------------------------------------------------------
  always_ff @(posedge pll_clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      adc_ena_q     <= 1'b0;
      div_cnt_q     <= '0;
      adc_clk_q     <= 1'b0;
      done_sync_q   <= '0;
      conv_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      adc_convert_q <= 1'b0;
      inputsrc_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      rd_data_q     <= '0;
      overflow_q    <= 1'b0;
      timeout_q     <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      adc_ena_q     <= adc_ena_d;
      div_cnt_q     <= div_cnt_d;
      adc_clk_q     <= adc_clk_d;
      done_sync_q   <= done_sync_d;
      conv_cnt_q    <= conv_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      adc_convert_q <= adc_convert_d;
      inputsrc_q    <= inputsrc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      rd_data_q     <= rd_data_d;
      overflow_q    <= overflow_d;
      timeout_q     <= timeout_d;
      irq_q         <= irq_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge pll_clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= adc.adc_data;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign adc.adc_ena      = adc_ena_q;
  assign adc.adc_convert  = adc_convert_q;
  assign adc.adc_clk      = adc_clk_q;
  assign adc.adc_inputsrc = inputsrc_q;

  assign rd_data  = rd_data_q;
  assign level    = level_q;
  assign empty    = fifo_empty;
  assign full     = fifo_full;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;
  assign busy     = (state_q != S_IDLE);
  assign irq      = irq_q;

endmodule

// File: tb/tb_adc_capture_seq.sv
// tb_adc_capture_seq
//   Directed bench for adc_capture_seq with a behavioural ADC macro model.
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_adc_capture_seq;
  logic       pll_clk;
  logic       reset;
  logic       cfg_ena;
  logic [7:0] cfg_clkdiv;
  logic [1:0] cfg_inputsrc;
  logic       start;
  logic       cont;
  logic       clear_flags;
  logic       rd_en;
  logic [9:0] rd_data;
  logic       empty, full, overflow, timeout, busy, irq;
  logic [4:0] level;

  adc_capture_seq_if ifc ();

  adc_capture_seq #(.FIFO_DEPTH(4), .TIMEOUT(1023)) dut (
    .pll_clk      (pll_clk),
    .reset        (reset),
    .cfg_ena      (cfg_ena),
    .cfg_clkdiv   (cfg_clkdiv),
    .cfg_inputsrc (cfg_inputsrc),
    .start        (start),
    .cont         (cont),
    .clear_flags  (clear_flags),
    .adc          (ifc.master),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .timeout      (timeout),
    .busy         (busy),
    .irq          (irq),
    .level        (level)
  );

  int         total = 0;
  int         bad   = 0;
  bit         model_on;
  int         model_delay;
  int         model_idx;
  logic [9:0] model_vals [0:7];

  initial begin
    pll_clk = 1'b0;
    forever #5 pll_clk = ~pll_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1);
  end

  // ADC macro model: done pulse (3 cycles) model_delay cycles after convert rises
  initial begin
    ifc.adc_done = 1'b0;
    ifc.adc_data = '0;
    forever begin
      @(posedge ifc.adc_convert);
      if (model_on) begin
        repeat (model_delay) @(posedge pll_clk);
        #2;
        ifc.adc_data = model_vals[model_idx % 8];
        model_idx    = model_idx + 1;
        ifc.adc_done = 1'b1;
        repeat (3) @(posedge pll_clk);
        #2;
        ifc.adc_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge pll_clk);
    #1;
  endtask

  function automatic logic [25:0] snap();
    return {ifc.adc_ena, ifc.adc_convert, ifc.adc_clk, ifc.adc_inputsrc, level,
            rd_data, empty, full, overflow, timeout, busy, irq};
  endfunction

  // Run from a sample where adc_convert is high; counts high samples until it falls.
  task automatic count_convert(output int hc, output bit ok);
    hc = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ifc.adc_convert) hc++;
      else if (hc > 0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [25:0] exp_v;
    exp_v = {1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    reset = 1'b1; cfg_ena = 1'b0; cfg_clkdiv = 8'd1; cfg_inputsrc = 2'd0;
    start = 1'b0; cont = 1'b0; clear_flags = 1'b0; rd_en = 1'b0;
    model_on = 1'b0; model_delay = 20; model_idx = 0;
    repeat (3) tick();
    total++;
    if (snap() !== exp_v) begin bad++; $display("FAIL reset_hold got=%h exp=%h", snap(), exp_v); end
    #3 reset = 1'b0;
    tick(); tick();
    total++;
    if (snap() !== exp_v) begin bad++; $display("FAIL reset_release got=%h exp=%h", snap(), exp_v); end
  endtask

  task automatic test_single();
    int  hc, tg;
    bit  ok;
    logic prev;
    model_on = 1'b1; model_delay = 20; model_idx = 0; model_vals[0] = 10'h2A5;
    cfg_clkdiv = 8'd1; cfg_inputsrc = 2'd2; cfg_ena = 1'b1;
    tick(); tick();
    total++;
    if (ifc.adc_ena !== 1'b1) begin bad++; $display("FAIL adc_ena got=%b exp=1", ifc.adc_ena); end
    repeat (4) tick();
    prev = ifc.adc_clk; tg = 0;
    repeat (16) begin tick(); if (ifc.adc_clk !== prev) tg++; prev = ifc.adc_clk; end
    total++;
    if (tg != 8) begin bad++; $display("FAIL clkdiv1_toggles got=%0d exp=8", tg); end
    cfg_clkdiv = 8'd3;
    repeat (10) tick();
    prev = ifc.adc_clk; tg = 0;
    repeat (16) begin tick(); if (ifc.adc_clk !== prev) tg++; prev = ifc.adc_clk; end
    total++;
    if (tg != 4) begin bad++; $display("FAIL clkdiv3_toggles got=%0d exp=4", tg); end
    cfg_clkdiv = 8'd1;
    repeat (10) tick();

    start = 1'b1; tick(); start = 1'b0;
    count_convert(hc, ok);
    total++;
    if (!ok || hc != 4) begin bad++; $display("FAIL convert_len got=%0d exp=4 ended=%b", hc, ok); end
    total++;
    if (ifc.adc_inputsrc !== 2'd2) begin bad++; $display("FAIL inputsrc_latch got=%0d exp=2", ifc.adc_inputsrc); end
    cfg_inputsrc = 2'd1;
    start = 1'b1; tick(); start = 1'b0;   // arrives while busy, must be dropped
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin tick(); if (level == 5'd1) begin ok = 1'b1; break; end end
    total++;
    if (!ok) begin bad++; $display("FAIL single_capture_wait got=level %0d exp=1", level); end
    tick(); tick();
    total++;
    if (rd_data !== 10'h2A5 || level !== 5'd1 || empty !== 1'b0 || irq !== 1'b1)
      begin bad++; $display("FAIL single_result got=%h/%0d/%b/%b exp=2a5/1/0/1", rd_data, level, empty, irq); end
    total++;
    if (ifc.adc_inputsrc !== 2'd2) begin bad++; $display("FAIL inputsrc_hold got=%0d exp=2", ifc.adc_inputsrc); end
    repeat (10) tick();
    total++;
    if (busy !== 1'b0 || level !== 5'd1) begin bad++; $display("FAIL start_ignored got=busy %b level %0d exp=0/1", busy, level); end

    rd_en = 1'b1; tick(); rd_en = 1'b0;
    total++;
    if (level !== 5'd0 || empty !== 1'b1 || rd_data !== 10'h2A5)
      begin bad++; $display("FAIL pop_last got=%0d/%b/%h exp=0/1/2a5", level, empty, rd_data); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    total++;
    if (level !== 5'd0 || rd_data !== 10'h2A5 || irq !== 1'b0)
      begin bad++; $display("FAIL pop_empty got=%0d/%h/%b exp=0/2a5/0", level, rd_data, irq); end
  endtask

  task automatic test_cont();
    bit ok;
    model_idx = 0;
    for (int i = 0; i < 5; i++) model_vals[i] = 10'h101 + 10'(i);
    cont = 1'b1; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (overflow) begin cont = 1'b0; ok = 1'b1; break; end
    end
    cont = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL cont_overflow_wait got=0 exp=1"); end
    tick();
    total++;
    if (level !== 5'd4 || full !== 1'b1 || overflow !== 1'b1 || rd_data !== 10'h101 || busy !== 1'b0)
      begin bad++; $display("FAIL cont_full got=%0d/%b/%b/%h/%b exp=4/1/1/101/0", level, full, overflow, rd_data, busy); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data !== 10'h101 + 10'(i)) begin bad++; $display("FAIL cont_pop%0d got=%h exp=%h", i, rd_data, 10'h101 + 10'(i)); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL cont_drained got=%b exp=1", empty); end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL clear_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_full_read();
    bit ok;
    logic [9:0] exp_d;
    model_idx = 0;
    model_vals[0] = 10'h011; model_vals[1] = 10'h022; model_vals[2] = 10'h033;
    model_vals[3] = 10'h044; model_vals[4] = 10'h055;
    cont = 1'b1; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (level == 5'd4) begin cont = 1'b0; ok = 1'b1; break; end
    end
    cont = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL fill_wait got=level %0d exp=4", level); end
    tick();
    start = 1'b1; tick(); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin tick(); if (ifc.adc_done) begin ok = 1'b1; break; end end
    total++;
    if (!ok) begin bad++; $display("FAIL done_wait got=0 exp=1"); end
    tick(); tick();             // FSM now in CAPTURE
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    total++;
    if (level !== 5'd4 || overflow !== 1'b0 || full !== 1'b1 || rd_data !== 10'h022)
      begin bad++; $display("FAIL full_rw got=%0d/%b/%b/%h exp=4/0/1/022", level, overflow, full, rd_data); end
    exp_d = 10'h022;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data !== exp_d) begin bad++; $display("FAIL full_rw_pop%0d got=%h exp=%h", i, rd_data, exp_d); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      exp_d = exp_d + 10'h011;
    end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    total++;
    if (level !== 5'd0 || empty !== 1'b1 || rd_data !== 10'h055)
      begin bad++; $display("FAIL empty_read got=%0d/%b/%h exp=0/1/055", level, empty, rd_data); end
  endtask

  task automatic test_timeout();
    int hc, cnt;
    bit ok, got;
    model_on = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    count_convert(hc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL timeout_convert_end got=0 exp=1"); end
    cnt = 0; got = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      tick(); cnt++;
      if (timeout) begin got = 1'b1; break; end
    end
    total++;
    if (!got || cnt != 1023) begin bad++; $display("FAIL timeout_cycles got=%0d seen=%b exp=1023", cnt, got); end
    total++;
    if (level !== 5'd0 || busy !== 1'b0) begin bad++; $display("FAIL timeout_state got=%0d/%b exp=0/0", level, busy); end
    tick();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL timeout_irq got=%b exp=1", irq); end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL clear_timeout got=%b exp=0", timeout); end
    tick();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_ena_drop();
    int  hc, highs;
    bit  ok;
    model_on = 1'b1; model_delay = 20; model_idx = 0;
    model_vals[0] = 10'h155; model_vals[1] = 10'h3FF;
    start = 1'b1; tick(); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin tick(); if (level == 5'd1) begin ok = 1'b1; break; end end
    total++;
    if (!ok || rd_data !== 10'h155) begin bad++; $display("FAIL pre_drop got=%h seen=%b exp=155", rd_data, ok); end
    repeat (3) tick();
    model_delay = 30;
    start = 1'b1; tick(); start = 1'b0;
    count_convert(hc, ok);
    cfg_ena = 1'b0;
    tick(); tick();
    highs = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (ifc.adc_clk !== 1'b0 || ifc.adc_convert !== 1'b0) highs++;
    end
    total++;
    if (highs != 0) begin bad++; $display("FAIL drop_clk_held got=%0d exp=0", highs); end
    total++;
    if (level !== 5'd1 || rd_data !== 10'h155 || busy !== 1'b0 || ifc.adc_ena !== 1'b0)
      begin bad++; $display("FAIL drop_no_write got=%0d/%h/%b/%b exp=1/155/0/0", level, rd_data, busy, ifc.adc_ena); end
  endtask

  task automatic test_reset_mid();
    logic [25:0] exp_v;
    int seen;
    exp_v = {1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    cfg_ena = 1'b1; model_on = 1'b0;
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (ifc.adc_convert !== 1'b1) begin bad++; $display("FAIL mid_precondition got=%b exp=1", ifc.adc_convert); end
    tick();
    #2 reset = 1'b1;
    #1;
    total++;
    if (ifc.adc_convert !== 1'b0) begin bad++; $display("FAIL convert_async got=%b exp=0", ifc.adc_convert); end
    total++;
    if (snap() !== exp_v) begin bad++; $display("FAIL reset_mid got=%h exp=%h", snap(), exp_v); end
    tick(); tick();
    #3 reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy !== 1'b0 || ifc.adc_convert !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL post_reset_idle got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cont();
    test_full_read();
    test_timeout();
    test_ena_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
